ram_mfa_moc: RTL and testbench

Byte-addressed, big-endian instruction/data memory for the MIPS multicycle datapath; it sits directly downstream of the MAR/MDR path.
- The control unit raises MFA with an address, size and direction.
- The memory completes after a fixed wait and holds MOC high until MFA drops (four-phase handshake).
- Storage is a byte array named Mem, so benches can preload it hierarchically before Clear is released.

---
 rtl/ram_pkg.sv | 38 +++
 rtl/ram_lane_fmt.sv | 29 ++
 rtl/ram_mfa_moc.sv | 189 ++++++++++++++++++
 tb/tb_ram_mfa_moc.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the ram_mfa_moc memory block.
// Contents: size encodings, the handshake FSM state type,
// and small helpers for access width and alignment.
package ram_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Number of bytes moved by an access; encoding 11 behaves as a word.
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        logic [2:0] n;
        case (sz)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    // True when the address is not naturally aligned for the access width.
    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a_lo);
        logic m;
        case (sz)
            SZ_BYTE: m = 1'b0;
            SZ_HALF: m = a_lo[0];
            default: m = |a_lo;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ram_lane_fmt.sv
// Read-data formatter for ram_mfa_moc.
// Takes the four bytes fetched at A..A+3 (b0 at the lowest address),
// assembles them big-endian, right-justifies the result according to
// size and sign- or zero-extends byte/halfword values.
// Ports: b0..b3 fetched bytes, size access size, sgn sign-extend enable,
//        data 32-bit formatted read value.
module ram_lane_fmt
    import ram_pkg::*;
(
    input  logic [7:0]  b0,
    input  logic [7:0]  b1,
    input  logic [7:0]  b2,
    input  logic [7:0]  b3,
    input  logic [1:0]  size,
    input  logic        sgn,
    output logic [31:0] data
);

    // Big-endian assembly and extension of the fetched bytes.
    always_comb begin
        data = 32'h0000_0000;
        case (size)
            SZ_BYTE: data = {{24{sgn & b0[7]}}, b0};
            SZ_HALF: data = {{16{sgn & b0[7]}}, b0, b1};
            default: data = {b0, b1, b2, b3};
        endcase
    end

endmodule

// File: rtl/ram_mfa_moc.sv
// Byte-addressed big-endian memory with an MFA/MOC four-phase handshake.
// A request is sampled in IDLE, waits WAIT_CYC cycles in BUSY, performs the
// access on the BUSY->DONE edge, and holds MOC until MFA drops.
// Ports: Clk clock, Clear sync active-low reset, MFA request, RW 1=read,
//        Size access size, Signed read extension, Address byte address,
//        DataIn write data, DataOut registered read data, MOC completion.
// Option: define RAM_ALIGN_CHECK_EN to add AlignErr and suppress
//         misaligned accesses (writes dropped, reads return 0).
module ram_mfa_moc
    import ram_pkg::*;
#(
    parameter int ADDR_W   = 9,
    parameter int DEPTH    = 512,
    parameter int WAIT_CYC = 2
) (
    input  logic              Clk,
    input  logic              Clear,
    input  logic              MFA,
    input  logic              RW,
    input  logic [1:0]        Size,
    input  logic              Signed,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              MOC
`ifdef RAM_ALIGN_CHECK_EN
    ,
    output logic              AlignErr
`endif
);

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);

    // Storage is never reset so a hierarchical preload survives Clear.
    logic [7:0] Mem [0:DEPTH-1];

    state_t            state_r;
    state_t            next_s;
    logic [3:0]        cnt_r;
    logic [ADDR_W-1:0] req_addr_r;
    logic              req_rw_r;
    logic [1:0]        req_size_r;
    logic              req_signed_r;
    logic [31:0]       req_data_r;
    logic [31:0]       dout_r;
    logic              moc_r;
    logic              fire_s;
    logic              align_err_s;
    logic [ADDR_W-1:0] addr_s [0:3];
    logic [3:0]        we_s;
    logic [7:0]        wb_s [0:3];
    logic [31:0]       rd_fmt_s;

    assign fire_s  = (state_r == ST_BUSY) && (cnt_r == 4'd0);
    assign DataOut = dout_r;
    assign MOC     = moc_r;

`ifdef RAM_ALIGN_CHECK_EN
    logic err_r;
    assign align_err_s = misaligned(req_size_r, req_addr_r[1:0]);
    assign AlignErr    = err_r;
`else
    assign align_err_s = 1'b0;
`endif

    // Lane addresses A..A+3; ADDR_W-bit addition gives wrap modulo DEPTH.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            addr_s[k] = req_addr_r + ADDR_W'(k);
        end
    end

    ram_lane_fmt u_fmt (
        .b0   (Mem[addr_s[0]]),
        .b1   (Mem[addr_s[1]]),
        .b2   (Mem[addr_s[2]]),
        .b3   (Mem[addr_s[3]]),
        .size (req_size_r),
        .sgn  (req_signed_r),
        .data (rd_fmt_s)
    );

    // Write byte enables and lane data: MSB of the right-justified value lands at A.
    always_comb begin
        we_s = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            wb_s[k] = 8'h00;
        end
        case (req_size_r)
            SZ_BYTE: begin
                we_s    = 4'b0001;
                wb_s[0] = req_data_r[7:0];
            end
            SZ_HALF: begin
                we_s    = 4'b0011;
                wb_s[0] = req_data_r[15:8];
                wb_s[1] = req_data_r[7:0];
            end
            default: begin
                we_s    = 4'b1111;
                wb_s[0] = req_data_r[31:24];
                wb_s[1] = req_data_r[23:16];
                wb_s[2] = req_data_r[15:8];
                wb_s[3] = req_data_r[7:0];
            end
        endcase
    end

    // Memory write, only on the BUSY->DONE edge so reset can never tear a write.
    always_ff @(posedge Clk) begin
        if (Clear && fire_s && !req_rw_r && !align_err_s) begin
            for (int k = 0; k < 4; k++) begin
                if (we_s[k]) begin
                    Mem[addr_s[k]] <= wb_s[k];
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (!Clear) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: next_s = MFA ? ST_BUSY : ST_IDLE;
            ST_BUSY: next_s = (cnt_r == 4'd0) ? ST_DONE : ST_BUSY;
            ST_DONE: next_s = MFA ? ST_DONE : ST_IDLE;
            default: next_s = ST_IDLE;
        endcase
    end

    // Request capture, wait counter, read data and handshake outputs.
    always_ff @(posedge Clk) begin
        if (!Clear) begin
            cnt_r  <= 4'd0;
            dout_r <= 32'h0000_0000;
            moc_r  <= 1'b0;
`ifdef RAM_ALIGN_CHECK_EN
            err_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (MFA) begin
                        req_addr_r   <= Address;
                        req_rw_r     <= RW;
                        req_size_r   <= Size;
                        req_signed_r <= Signed;
                        req_data_r   <= DataIn;
                        cnt_r        <= CNT_LOAD;
                    end
                end
                ST_BUSY: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        moc_r <= 1'b1;
                        if (req_rw_r) begin
                            dout_r <= align_err_s ? 32'h0000_0000 : rd_fmt_s;
                        end
`ifdef RAM_ALIGN_CHECK_EN
                        err_r <= align_err_s;
`endif
                    end
                end
                ST_DONE: begin
                    if (!MFA) begin
                        moc_r <= 1'b0;
`ifdef RAM_ALIGN_CHECK_EN
                        err_r <= 1'b0;
`endif
                    end
                end
                default: begin
                    moc_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_mfa_moc.sv
// Self-checking bench for ram_mfa_moc: directed vector table, handshake and
// mid-operation reset sequences, then random accesses against a byte-array model.
module tb_ram_mfa_moc;
    import ram_pkg::*;

    logic        Clk;
    logic        Clear;
    logic        MFA;
    logic        RW;
    logic [1:0]  Size;
    logic        Signed;
    logic [8:0]  Address;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        MOC;
`ifdef RAM_ALIGN_CHECK_EN
    logic        AlignErr;
`endif

    ram_mfa_moc #(.ADDR_W(9), .DEPTH(512), .WAIT_CYC(2)) dut (
        .Clk     (Clk),
        .Clear   (Clear),
        .MFA     (MFA),
        .RW      (RW),
        .Size    (Size),
        .Signed  (Signed),
        .Address (Address),
        .DataIn  (DataIn),
        .DataOut (DataOut),
        .MOC     (MOC)
`ifdef RAM_ALIGN_CHECK_EN
        ,
        .AlignErr(AlignErr)
`endif
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0]  mdl [512];
    logic [31:0] last_dout;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] mdl_read(input logic [8:0] a, input logic [1:0] sz, input logic sg);
        int n = nbytes(sz);
        logic [31:0] v = 32'h0;
        for (int k = 0; k < n; k++) v = (v << 8) | 32'(mdl[(int'(a) + k) % 512]);
        if (sg && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (sg && n == 2 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic mdl_write(input logic [8:0] a, input logic [1:0] sz, input logic [31:0] d);
        int n = nbytes(sz);
        for (int k = 0; k < n; k++) mdl[(int'(a) + k) % 512] = 8'(d >> (8 * (n - 1 - k)));
    endtask

    function automatic bit mdl_mis(input logic [1:0] sz, input logic [8:0] a);
`ifdef RAM_ALIGN_CHECK_EN
        int n = nbytes(sz);
        return (n == 2 && (int'(a) % 2) != 0) || (n == 4 && (int'(a) % 4) != 0);
`else
        return 1'b0;
`endif
    endfunction

    // One full handshake; checks latency and MOC/AlignErr dropping after MFA falls.
    task automatic do_access(input logic rw, input logic [1:0] sz, input logic sg,
                             input logic [8:0] a, input logic [31:0] d,
                             output logic [31:0] dout, output logic err);
        int lat;
        @(negedge Clk);
        RW = rw; Size = sz; Signed = sg; Address = a; DataIn = d; MFA = 1'b1;
        lat = 0;
        do begin
            @(posedge Clk); #1;
            lat++;
        end while (!MOC && lat < 20);
        chk("latency", 32'(lat), 32'd3);
        dout = DataOut;
`ifdef RAM_ALIGN_CHECK_EN
        err = AlignErr;
`else
        err = 1'b0;
`endif
        @(negedge Clk);
        MFA = 1'b0;
        RW = ~rw; Address = ~a; DataIn = ~d;
        @(posedge Clk); #1;
        chk("moc_drop", 32'(MOC), 32'd0);
`ifdef RAM_ALIGN_CHECK_EN
        chk("alignerr_drop", 32'(AlignErr), 32'd0);
`endif
    endtask

    typedef struct {
        logic        rw;
        logic [1:0]  sz;
        logic        sg;
        logic [8:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [31:0] dout;
        logic        err;
        logic [31:0] exp;
        int          lat;
        int          bad;

        Clear = 1'b0; MFA = 1'b0; RW = 1'b1; Size = 2'd0; Signed = 1'b0;
        Address = 9'd0; DataIn = 32'h0;

        for (int i = 0; i < 512; i++) mdl[i] = 8'($urandom);
        mdl[0] = 8'h8C; mdl[1] = 8'h01; mdl[2] = 8'h00; mdl[3] = 8'h04;
        mdl[5] = 8'hF0; mdl[10] = 8'h12; mdl[11] = 8'h34;
        mdl[16] = 8'h11; mdl[17] = 8'h22; mdl[18] = 8'h33; mdl[19] = 8'h44;
        mdl[510] = 8'hAA; mdl[511] = 8'h55;
        for (int i = 0; i < 512; i++) dut.Mem[i] = mdl[i];

        repeat (2) @(posedge Clk);
        #1;
        chk("reset_moc", 32'(MOC), 32'd0);
        chk("reset_dout", DataOut, 32'h0);
        last_dout = 32'h0;
        @(negedge Clk);
        Clear = 1'b1;

        tbl[0]  = '{1'b1, 2'd2, 1'b0, 9'd0,   32'h0,         32'h8C01_0004};
        tbl[1]  = '{1'b1, 2'd0, 1'b1, 9'd5,   32'h0,         32'hFFFF_FFF0};
        tbl[2]  = '{1'b1, 2'd0, 1'b0, 9'd5,   32'h0,         32'h0000_00F0};
        tbl[3]  = '{1'b0, 2'd1, 1'b0, 9'd8,   32'h0000_BEEF, 32'h0000_00F0};
        tbl[4]  = '{1'b1, 2'd2, 1'b0, 9'd8,   32'h0,         32'hBEEF_1234};
        tbl[5]  = '{1'b1, 2'd0, 1'b0, 9'd10,  32'h0,         32'h0000_0012};
`ifdef RAM_ALIGN_CHECK_EN
        tbl[6]  = '{1'b1, 2'd2, 1'b0, 9'd510, 32'h0,         32'h0000_0000};
`else
        tbl[6]  = '{1'b1, 2'd2, 1'b0, 9'd510, 32'h0,         32'hAA55_8C01};
`endif
        tbl[7]  = '{1'b1, 2'd1, 1'b1, 9'd0,   32'h0,         32'hFFFF_8C01};
        tbl[8]  = '{1'b1, 2'd1, 1'b0, 9'd2,   32'h0,         32'h0000_0004};
        tbl[9]  = '{1'b0, 2'd0, 1'b0, 9'd20,  32'hFFFF_FF7E, 32'h0000_0004};
        tbl[10] = '{1'b1, 2'd0, 1'b1, 9'd20,  32'h0,         32'h0000_007E};
        tbl[11] = '{1'b1, 2'd3, 1'b0, 9'd0,   32'h0,         32'h8C01_0004};

        for (int i = 0; i < 12; i++) begin
            do_access(tbl[i].rw, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].d, dout, err);
            chk($sformatf("vec%0d", i), dout, tbl[i].exp);
            if (!tbl[i].rw && !mdl_mis(tbl[i].sz, tbl[i].a)) mdl_write(tbl[i].a, tbl[i].sz, tbl[i].d);
            last_dout = tbl[i].exp;
        end
        chk("hw_write_mem8_9", {24'h0, dut.Mem[8]} << 8 | {24'h0, dut.Mem[9]}, 32'h0000_BEEF);
        chk("hw_write_mem10", {24'h0, dut.Mem[10]}, 32'h0000_0012);

        // Handshake: hold MFA past MOC while inputs change to a write; no second access.
        @(negedge Clk);
        RW = 1'b1; Size = 2'd2; Signed = 1'b0; Address = 9'd0; MFA = 1'b1;
        lat = 0;
        do begin
            @(posedge Clk); #1;
            lat++;
        end while (!MOC && lat < 20);
        chk("hs_latency", 32'(lat), 32'd3);
        exp = mdl_read(9'd0, 2'd2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            RW = 1'b0; Address = 9'd0; DataIn = 32'h0BAD_F00D;
            @(posedge Clk); #1;
            chk("hs_moc_hold", 32'(MOC), 32'd1);
            chk("hs_dout_hold", DataOut, exp);
        end
        @(negedge Clk);
        MFA = 1'b0;
        @(posedge Clk); #1;
        chk("hs_moc_drop", 32'(MOC), 32'd0);
        chk("hs_no_write", {dut.Mem[0], dut.Mem[1], dut.Mem[2], dut.Mem[3]}, exp);
        do_access(1'b1, 2'd2, 1'b0, 9'd8, 32'h0, dout, err);
        chk("hs_new_access", dout, mdl_read(9'd8, 2'd2, 1'b0));

        // Reset during BUSY of a word write to 16 aborts it.
        @(negedge Clk);
        RW = 1'b0; Size = 2'd2; Address = 9'd16; DataIn = 32'hDEAD_BEEF; MFA = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Clear = 1'b0; MFA = 1'b0;
        @(posedge Clk); #1;
        chk("rst_moc", 32'(MOC), 32'd0);
        chk("rst_dout", DataOut, 32'h0);
        chk("rst_state", 32'(dut.state_r), 32'(ST_IDLE));
        @(negedge Clk);
        Clear = 1'b1;
        repeat (4) @(posedge Clk);
        #1;
        chk("rst_moc_after", 32'(MOC), 32'd0);
        chk("rst_mem16", {dut.Mem[16], dut.Mem[17], dut.Mem[18], dut.Mem[19]}, 32'h1122_3344);
        last_dout = 32'h0;

        // Random accesses against the model.
        for (int i = 0; i < 150; i++) begin
            logic        rw;
            logic [1:0]  sz;
            logic        sg;
            logic [8:0]  a;
            logic [31:0] d;
            bit          mis;
            rw = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 3) == 0) ? 9'(508 + $urandom_range(0, 3)) : 9'($urandom);
            d  = $urandom;
            mis = mdl_mis(sz, a);
            if (rw) exp = mis ? 32'h0 : mdl_read(a, sz, sg);
            else    exp = last_dout;
            do_access(rw, sz, sg, a, d, dout, err);
            chk("rand_dout", dout, exp);
            chk("rand_err", 32'(err), 32'(mis));
            if (!rw && !mis) mdl_write(a, sz, d);
            last_dout = exp;
        end

`ifdef RAM_ALIGN_CHECK_EN
        do_access(1'b0, 2'd2, 1'b0, 9'd2, 32'hFFFF_FFFF, dout, err);
        chk("align_err", 32'(err), 32'd1);
        chk("align_nowrite", {dut.Mem[2], dut.Mem[3], dut.Mem[4], dut.Mem[5]},
            {mdl[2], mdl[3], mdl[4], mdl[5]});
`endif

        bad = 0;
        for (int i = 0; i < 512; i++) if (dut.Mem[i] !== mdl[i]) bad++;
        chk("mem_final", 32'(bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
